// File: rtl/goldschmidt_pkg.sv
// Shared types and fixed-point helpers for the Goldschmidt divider.
// Helpers work on a wide container and are narrowed by the caller to its own WIDTH.
package goldschmidt_pkg;

  typedef enum logic [1:0] {IDLE, MUL_D, MUL_N, DONE} gs_state_t;

  localparam int MAX_WIDTH = 64;

  // Fixed-point 1.0 in Q1.(width-1), i.e. 2^(width-1).
  function automatic logic [MAX_WIDTH-1:0] one_of(input int width);
    return 64'd1 << (width - 1);
  endfunction

  // 2 - x in Q1.(width-1): two's complement of x modulo 2^width.
  function automatic logic [MAX_WIDTH-1:0] two_minus(input logic [MAX_WIDTH-1:0] x,
                                                     input int width);
    logic [MAX_WIDTH-1:0] mask;
    mask = (one_of(width) << 1) - 64'd1;
    return (~x + 64'd1) & mask;
  endfunction

endpackage

// File: rtl/goldschmidt_div_fxp_mul.sv
// Combinational Q1.(WIDTH-1) multiplier: full product, optional half-up rounding,
// rescale by 2^(WIDTH-1) and saturate to all ones on overflow.
module fxp_mul
  import goldschmidt_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ROUND = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);

  localparam logic [2*WIDTH-1:0] RND = (ROUND != 0) ? (2*WIDTH)'(one_of(WIDTH - 1)) : '0;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     shifted;
  logic               unused_low;

  // The sum cannot wrap: (2^W-1)^2 + 2^(W-2) < 2^(2W).
  assign prod       = ({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b}) + RND;
  assign shifted    = prod[2*WIDTH-1:WIDTH-1];
  assign unused_low = ^prod[WIDTH-2:0];
  assign p          = shifted[WIDTH] ? '1 : shifted[WIDTH-1:0];

endmodule

// File: rtl/goldschmidt_div.sv
// Self-sequencing Goldschmidt divider: one shared multiplier alternates between
// the denominator and numerator passes, with valid/ready on both sides.
module goldschmidt_div
  import goldschmidt_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 4,
  parameter int ROUND = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] n_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] ia_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q_o,
  output logic             err_o
);

  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER);

  gs_state_t        state_reg, state_next;
  logic [WIDTH-1:0] n_reg, d_reg, k_reg, q_reg;
  logic [CW-1:0]    cnt_reg;
  logic             err_reg;
  logic [WIDTH-1:0] mul_a, mul_p;
  logic             ops_bad;

  // A denominator below 1.0 or a zero seed would never converge.
  assign ops_bad = !d_i[WIDTH-1] || (ia_i == '0);
  assign mul_a   = (state_reg == MUL_D) ? d_reg : n_reg;

  fxp_mul #(.WIDTH(WIDTH), .ROUND(ROUND)) u_mul (
    .a (mul_a),
    .b (k_reg),
    .p (mul_p)
  );

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ops_bad ? DONE : MUL_D;
      end
      MUL_D: state_next = MUL_N;
      MUL_N: state_next = (cnt_reg == LAST) ? DONE : MUL_D;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      d_reg     <= '0;
      k_reg     <= '0;
      q_reg     <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (in_valid) begin
          n_reg   <= n_i;
          d_reg   <= d_i;
          k_reg   <= ia_i;
          cnt_reg <= '0;
          if (ops_bad) begin
            q_reg   <= '1;
            err_reg <= 1'b1;
          end
        end
        MUL_D: d_reg <= mul_p;
        MUL_N: begin
          // d_reg already holds this iteration's D, so K = 2 - D_new.
          n_reg <= mul_p;
          k_reg <= WIDTH'(two_minus(MAX_WIDTH'(d_reg), WIDTH));
          if (cnt_reg == LAST) q_reg <= mul_p;
          else                 cnt_reg <= cnt_reg + CW'(1);
        end
        DONE: if (out_ready) err_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign q_o   = q_reg;
  assign err_o = err_reg;

endmodule

// File: tb/tb_goldschmidt_div.sv
// Scoreboard bench: three divider configurations, expected results queued at
// accept time and checked by a monitor on every output handshake.
module tb_goldschmidt_div;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [23:0] q;
    int          tol;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb0[$], sb1[$], sb2[$];

  logic        a_iv, a_ir, a_ov, a_or, a_err;
  logic [15:0] a_n, a_d, a_ia, a_q;
  logic        b_iv, b_ir, b_ov, b_or, b_err;
  logic [15:0] b_n, b_d, b_ia, b_q;
  logic        c_iv, c_ir, c_ov, c_or, c_err;
  logic [23:0] c_n, c_d, c_ia, c_q;

  goldschmidt_div #(.WIDTH(16), .ITER(4), .ROUND(0)) dut_a (
    .clk(clk), .reset(rst), .in_valid(a_iv), .in_ready(a_ir), .n_i(a_n), .d_i(a_d),
    .ia_i(a_ia), .out_valid(a_ov), .out_ready(a_or), .q_o(a_q), .err_o(a_err));
  goldschmidt_div #(.WIDTH(16), .ITER(4), .ROUND(1)) dut_b (
    .clk(clk), .reset(rst), .in_valid(b_iv), .in_ready(b_ir), .n_i(b_n), .d_i(b_d),
    .ia_i(b_ia), .out_valid(b_ov), .out_ready(b_or), .q_o(b_q), .err_o(b_err));
  goldschmidt_div #(.WIDTH(24), .ITER(2), .ROUND(0)) dut_c (
    .clk(clk), .reset(rst), .in_valid(c_iv), .in_ready(c_ir), .n_i(c_n), .d_i(c_d),
    .ia_i(c_ia), .out_valid(c_ov), .out_ready(c_or), .q_o(c_q), .err_o(c_err));

  task automatic check(input string name, input longint act, input longint lo, input longint hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h..0x%0h", name, act, lo, hi);
    end
  endtask

  function automatic exp_t mk(input logic [23:0] q, input int tol, input logic err, input int lat);
    exp_t e;
    e.q = q; e.tol = tol; e.err = err; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  task automatic push(input int id, input exp_t e);
    case (id)
      0: sb0.push_back(e);
      1: sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic drive(input int id, input logic v, input logic [23:0] n, d, ia);
    case (id)
      0: begin a_iv = v; a_n = n[15:0]; a_d = d[15:0]; a_ia = ia[15:0]; end
      1: begin b_iv = v; b_n = n[15:0]; b_d = d[15:0]; b_ia = ia[15:0]; end
      default: begin c_iv = v; c_n = n; c_d = d; c_ia = ia; end
    endcase
  endtask

  function automatic logic ready_of(input int id);
    case (id)
      0: return a_ir;
      1: return b_ir;
      default: return c_ir;
    endcase
  endfunction

  // Present operands until accepted; the expected result is queued at the accept edge.
  task automatic send(input int id, input logic [23:0] n, d, ia, input exp_t e, output int acc);
    logic r;
    @(posedge clk); #1;
    drive(id, 1'b1, n, d, ia);
    acc = -1;
    for (int w = 0; w < 100 && acc < 0; w++) begin
      @(negedge clk); r = ready_of(id);
      @(posedge clk); #1;
      if (r) begin
        acc = cyc; e.acc = cyc;
        push(id, e);
      end
    end
    drive(id, 1'b0, n, d, ia);
    if (acc < 0) check("accept_timeout", 0, 1, 1);
  endtask

  int   rise[3];
  logic prev_v[3] = '{1'b0, 1'b0, 1'b0};

  task automatic mon(input int id, input logic ov, input logic ordy, input logic [23:0] q, input logic err);
    exp_t e;
    logic have;
    if (ov && !prev_v[id]) rise[id] = cyc;
    prev_v[id] = ov;
    if (ov && ordy) begin
      have = 1'b0;
      case (id)
        0: if (sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
        1: if (sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
        default: if (sb2.size() > 0) begin e = sb2.pop_front(); have = 1'b1; end
      endcase
      if (!have) check($sformatf("unexpected_out%0d", id), 1, 0, 0);
      else begin
        check($sformatf("q%0d", id), q, longint'(e.q) - e.tol, longint'(e.q) + e.tol);
        check($sformatf("err%0d", id), err, e.err, e.err);
        check($sformatf("latency%0d", id), rise[id] - e.acc, e.lat, e.lat);
        $display("out%0d q=0x%0h err=%0b latency=%0d", id, q, err, rise[id] - e.acc);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_ov, a_or, {8'h00, a_q}, a_err);
    mon(1, b_ov, b_or, {8'h00, b_q}, b_err);
    mon(2, c_ov, c_or, c_q, c_err);
  end

  task automatic drain(input string name);
    int k;
    k = 0;
    while (k < 300 && (sb0.size() + sb1.size() + sb2.size()) > 0) begin
      @(negedge clk); k++;
    end
    check(name, sb0.size() + sb1.size() + sb2.size(), 0, 0);
  endtask

  initial begin
    int   acc, acc2;
    logic got, r;
    exp_t e;
    rst = 1'b1;
    a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;
    drive(0, 1'b0, 0, 0, 0); drive(1, 1'b0, 0, 0, 0); drive(2, 1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", a_ir, 1, 1);
    check("rst_out_valid", a_ov, 0, 0);
    check("rst_q", a_q, 0, 0);
    check("rst_err", a_err, 0, 0);

    // Latency counts edges after the accept edge; the error path is visible right after it.
    send(0, 24'hC000, 24'h8000, 24'h8000, mk(24'hC000, 0, 1'b0, 10), acc);
    send(0, 24'hC000, 24'hA000, 24'h6666, mk(24'h9999, 4, 1'b0, 10), acc);
    send(0, 24'hC000, 24'h4000, 24'h8000, mk(24'hFFFF, 0, 1'b1, 0), acc);
    send(0, 24'hC000, 24'h8000, 24'h0000, mk(24'hFFFF, 0, 1'b1, 0), acc);
    send(1, 24'hC000, 24'hA000, 24'h6666, mk(24'h9999, 2, 1'b0, 10), acc);

    // Each result costs 2*(ITER+1) compute cycles plus one DONE and one IDLE cycle.
    send(2, 24'h800000, 24'h800000, 24'h800000, mk(24'h800000, 0, 1'b0, 6), acc);
    send(2, 24'h800000, 24'h800000, 24'h800000, mk(24'h800000, 0, 1'b0, 6), acc2);
    check("throughput", acc2 - acc, 8, 8);
    drain("drain_basic");

    // Backpressure: hold the result, offer a second operand that must wait.
    @(posedge clk); #1 a_or = 1'b0;
    send(0, 24'hC000, 24'h8000, 24'h8000, mk(24'hC000, 0, 1'b0, 10), acc);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk); got = a_ov;
    end
    check("bp_valid_seen", got, 1, 1);
    @(posedge clk); #1;
    drive(0, 1'b1, 24'hA000, 24'h8000, 24'h8000);
    repeat (5) begin
      @(negedge clk);
      check("bp_q_stable", a_q, 16'hC000, 16'hC000);
      check("bp_in_ready", a_ir, 0, 0);
      check("bp_out_valid", a_ov, 1, 1);
    end
    @(posedge clk); #1 a_or = 1'b1;
    @(negedge clk);
    check("bp_no_ready_at_handshake", a_ir, 0, 0);
    @(negedge clk);
    check("bp_ready_after", a_ir, 1, 1);
    check("bp_valid_dropped", a_ov, 0, 0);
    @(posedge clk); #1;
    e = mk(24'hA000, 0, 1'b0, 10); e.acc = cyc;
    push(0, e);
    drive(0, 1'b0, 0, 0, 0);
    drain("drain_bp");

    // Reset in cycle 4 of a division abandons it; no result is queued.
    @(posedge clk); #1;
    drive(0, 1'b1, 24'hC000, 24'hA000, 24'h6666);
    @(negedge clk); r = a_ir;
    @(posedge clk); #1;
    drive(0, 1'b0, 0, 0, 0);
    check("rm_accept", r, 1, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rm_in_ready", a_ir, 1, 1);
    check("rm_out_valid", a_ov, 0, 0);
    check("rm_q", a_q, 0, 0);
    check("rm_err", a_err, 0, 0);
    send(0, 24'hC000, 24'h8000, 24'h8000, mk(24'hC000, 0, 1'b0, 10), acc);
    drain("drain_final");
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
